// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: a WIDTH-bit add or subtract is processed DIGIT bits per clock,
// LSB digit first, behind a start/busy/done handshake with registered sum, carry and overflow.
module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_next;
  logic             msb_cin;
  logic             last;

  // One digit slice of A + B' + running carry. On the final digit the slice's top bit is the
  // operand MSB, so the carry into the MSB falls out as a ^ b ^ s of that bit.
  always_comb begin
    dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    acc_next = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    msb_cin  = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
    last     = (cnt == CW'(N - 1));
  end

  // DONE accepts a new start exactly like IDLE so back-to-back operations need no gap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= dsum[DIGIT];
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= acc_next;
            cout  <= dsum[DIGIT];
            ovf   <= msb_cin ^ dsum[DIGIT];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench: three instances (DIGIT = 2, 1, 8) share operands; expected results are queued
// at each accepted start and popped when the matching instance raises done.
module tb_digit_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [7:0] sum_v [3];
  logic [2:0] cout_v;
  logic [2:0] ovf_v;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         due;
  } exp_t;

  exp_t sb [3][$];
  int   lat [3];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) dut_d2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  function automatic exp_t model(input logic [7:0] xa, input logic [7:0] xb, input logic xcin,
                                 input logic xsub, input int due);
    exp_t       e;
    logic [7:0] bb;
    logic [8:0] full;
    bb    = xsub ? ~xb : xb;
    full  = {1'b0, xa} + {1'b0, bb} + {8'd0, (xsub ? 1'b1 : xcin)};
    e.s   = full[7:0];
    e.co  = full[8];
    e.ov  = (xa[7] == bb[7]) && (full[7] != xa[7]);
    e.due = due;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int idx, input logic [31:0] obs,
                             input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, expv);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, "_busy"}, i, 32'(busy_v[i]), 32'd0);
      checkOutput({tag, "_done"}, i, 32'(done_v[i]), 32'd0);
      checkOutput({tag, "_sum"},  i, 32'(sum_v[i]),  32'd0);
      checkOutput({tag, "_cout"}, i, 32'(cout_v[i]), 32'd0);
      checkOutput({tag, "_ovf"},  i, 32'(ovf_v[i]),  32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input logic [7:0] xa, input logic [7:0] xb,
                               input logic xcin, input logic xsub);
    @(negedge clk);
    a = xa; b = xb; cin = xcin; sub = xsub;
    start_v = mask;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (mask[i]) sb[i].push_back(model(xa, xb, xcin, xsub, cyc + lat[i]));
    start_v = 3'b000;
  endtask

  task automatic waitIdle();
    int pending;
    pending = sb[0].size() + sb[1].size() + sb[2].size();
    for (int k = 0; k < 60 && pending != 0; k++) begin
      @(negedge clk);
      #1;
      pending = sb[0].size() + sb[1].size() + sb[2].size();
    end
    n_vec++;
    assert (pending == 0) else begin
      n_err++;
      $error("[TB] FAIL done_timeout observed pending=%0d expected pending=0", pending);
      for (int i = 0; i < 3; i++) sb[i].delete();
    end
  endtask

  initial begin
    exp_t e;
    lat[0] = 4; lat[1] = 8; lat[2] = 1;
    rst = 1'b1; start_v = 3'b111; sub = 1'b0; a = 8'h3C; b = 8'h55; cin = 1'b0;

    // Scoreboard monitor: every done must match the oldest pending result at its due cycle.
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          n_vec++;
          assert ((busy_v[i] & done_v[i]) !== 1'b1) else begin
            n_err++;
            $error("[TB] FAIL busy_and_done dut%0d observed both high expected exclusive", i);
          end
          if (done_v[i] === 1'b1) begin
            n_vec++;
            assert (sb[i].size() != 0) else begin
              n_err++;
              $error("[TB] FAIL spurious_done dut%0d observed done=1 expected no pending op", i);
            end
            if (sb[i].size() != 0) begin
              e = sb[i].pop_front();
              checkOutput("sum",     i, 32'(sum_v[i]),  32'(e.s));
              checkOutput("cout",    i, 32'(cout_v[i]), 32'(e.co));
              checkOutput("ovf",     i, 32'(ovf_v[i]),  32'(e.ov));
              checkOutput("latency", i, 32'(cyc),       32'(e.due));
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset");
    rst = 1'b0;
    start_v = 3'b000;
    @(negedge clk);
    checkIdleZero("post_reset");

    applyStimulus(3'b111, 8'h3C, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("busy_run", 0, 32'(busy_v[0]), 32'd1);
    checkOutput("busy_run", 1, 32'(busy_v[1]), 32'd1);
    waitIdle();
    applyStimulus(3'b111, 8'hFF, 8'h01, 1'b0, 1'b0);
    waitIdle();
    applyStimulus(3'b111, 8'h7F, 8'h00, 1'b1, 1'b0);
    waitIdle();
    applyStimulus(3'b111, 8'h05, 8'h07, 1'b1, 1'b1);
    waitIdle();
    applyStimulus(3'b111, 8'h80, 8'h01, 1'b0, 1'b1);
    waitIdle();

    // Second start while busy must be ignored and operand changes must not leak in.
    applyStimulus(3'b001, 8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'hAA; sub = 1'b1; start_v = 3'b001;
    @(posedge clk);
    #1;
    start_v = 3'b000;
    @(negedge clk);
    checkOutput("busy_ignore", 0, 32'(busy_v[0]), 32'd1);
    waitIdle();
    repeat (6) @(negedge clk);

    // start held high: accepts at E0, E5, E10, completing every 5 cycles.
    @(negedge clk);
    a = 8'h21; b = 8'h43; cin = 1'b1; sub = 1'b0; start_v = 3'b001;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) @(posedge clk);
      else repeat (5) @(posedge clk);
      #1;
      sb[0].push_back(model(8'h21, 8'h43, 1'b1, 1'b0, cyc + 4));
    end
    start_v = 3'b000;
    waitIdle();

    // Mid-operation reset at E2: no done may follow and outputs clear.
    applyStimulus(3'b001, 8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb[0].delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkIdleZero("mid_reset");
    repeat (10) @(negedge clk);
    checkOutput("mid_reset_sum", 0, 32'(sum_v[0]), 32'd0);

    applyStimulus(3'b111, 8'h05, 8'h07, 1'b0, 1'b1);
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised, digit-serial adder/subtractor that processes a WIDTH-bit operation DIGIT bits per clock, LSB digit first. It uses a start/busy/done handshake and registers sum, carry and signed overflow. It generalises the combinational full adder and 3-bit adder into a single sequential arithmetic unit. It serves area-constrained datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- DIGIT, 2, bits processed per cycle; must divide WIDTH. N = WIDTH/DIGIT digit cycles.
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add; ignored when sub=1; captured with start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result, held until the next completion.
- cout  output  1  raw carry-out of the MSB.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, sub, cin, and b, with b inverted when sub=1.
  - Effective carry-in is sub ? 1 : cin.
  - Digit counter is cleared; next state is RUN.
- RUN:
  - Each edge adds one DIGIT-bit slice of A, B' and the running carry.
  - The sum digit is shifted into an internal shift register; the carry register is updated.
  - After digit N-1, the state goes to DONE.
- DONE:
  - sum/cout/ovf output registers are loaded from the internal result; done=1.
  - Next state is IDLE. start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations.
- Arithmetic:
  - sum = (A + B' + c0) mod 2^WIDTH.
  - cout = bit WIDTH of that sum. For sub, cout=1 means no borrow.
  - ovf = carry into MSB XOR carry out of MSB.
- start while busy=1 is ignored; operands are not re-captured.
- Input changes during RUN have no effect.
- Output registers change only on the DONE transition. They are never partially updated.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, counter 0.
- rst=1 at any edge overrides everything:
  - A mid-operation reset aborts the operation; done is never asserted for it.
  - Outputs return to 0.
- start accepted at edge E0:
  - busy=1 from after E0 through after E(N-1).
  - busy=0 and done=1 after E(N); done=0 after E(N+1) unless a new completion occurs.
- Latency, start edge to done high: N cycles.
- Throughput: one operation per N+1 cycles when start is held high.
- DIGIT = WIDTH (N=1): RUN lasts one cycle, and done is high after E1.
- DIGIT = 1: pure bit-serial operation, N = WIDTH.
- busy and done are never high together.

## Test plan
Settings: WIDTH=8, DIGIT=2 (N=4) unless noted.
- Reset:
  - Stimulus: hold rst 2 cycles with start=1.
  - Required: busy=0, done=0, sum=0x00, cout=0, ovf=0; no operation starts.
- Add with signed overflow:
  - Stimulus: a=0x3C, b=0x55, cin=0, sub=0, start pulse at E0.
  - Required: busy high for 4 cycles; done after E4; sum=0x91, cout=0, ovf=1.
- Add with wrap and with carry-in:
  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - Then 0x7F+0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Subtract:
  - 0x05-0x07, cin=1 (ignored) -> sum=0xFE, cout=0, ovf=0.
  - 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Handshake boundaries:
  - Start 0x10+0x20, then pulse start with 0xAA/0xAA at E2 while busy -> result 0x30 only; the second request is ignored.
  - start held high continuously -> done every 5 cycles.
  - rst at E2 of an operation -> no done; outputs 0x00.
- Parameter sweep:
  - Repeat the add and subtract vectors with DIGIT=1 (done after E8) and DIGIT=8 (done after E1); results are identical.
